// File: rtl/store_port_ctrl.sv
// store_port_ctrl
// Issues MEM-stage store instructions to the data memory. Sub-word
// stores are turned into a word-aligned address, lane-replicated write data
// and byte enables. Misaligned or illegal stores are rejected with a
// one-cycle fault pulse and are never sent to memory.
//
// Ports
//   clk              clock, rising edge
//   reset            asynchronous, active-low reset
//   MEM_store_req    MEM-stage instruction is a store
//   MEM_funct3       store width (0 SB, 1 SH, 2 SW, others illegal)
//   MEM_addr         byte address
//   MEM_rs2_data     store data, LSB-aligned
//   DM_ready         memory accepts the current request
//   DM_req           write request valid
//   DM_addr          word-aligned address
//   DM_wdata         lane-replicated write data
//   DM_bwe           byte write enables (bit n -> byte n)
//   MEM_stall        freeze upstream pipeline registers (combinational)
//   MEM_store_fault  one-cycle pulse for a rejected store
//   fault_addr       address of the most recent rejected store
//   store_count      completed memory handshakes, modulo 2^16
`timescale 1ns/1ps
module store_port_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_store_req,
    input  logic [2:0]  MEM_funct3,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_rs2_data,
    input  logic        DM_ready,
    output logic        DM_req,
    output logic [31:0] DM_addr,
    output logic [31:0] DM_wdata,
    output logic [3:0]  DM_bwe,
    output logic        MEM_stall,
    output logic        MEM_store_fault,
    output logic [31:0] fault_addr,
    output logic [15:0] store_count
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_aligned;
    logic [31:0] w_wdata;
    logic [3:0]  w_bwe;
    logic        w_accept;
    logic        w_done;
    logic        w_fault;
    logic        w_stall;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_bwe;
    logic        r_fault;
    logic [31:0] r_faddr;
    logic [15:0] r_count;

    // Width decode: alignment check, data replication and byte enables.
    always_comb begin
        w_aligned = 1'b0;
        w_wdata   = MEM_rs2_data;
        w_bwe     = 4'b0000;
        case (MEM_funct3)
            3'd0: begin
                w_aligned = 1'b1;
                w_wdata   = {4{MEM_rs2_data[7:0]}};
                w_bwe     = 4'b0001 << MEM_addr[1:0];
            end
            3'd1: begin
                w_aligned = ~MEM_addr[0];
                w_wdata   = {2{MEM_rs2_data[15:0]}};
                w_bwe     = MEM_addr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                w_aligned = (MEM_addr[1:0] == 2'b00);
                w_wdata   = MEM_rs2_data;
                w_bwe     = 4'b1111;
            end
            default: ;
        endcase
    end

    // Next state. MEM_store_req is ignored while a request is outstanding:
    // the instruction still sitting in MEM is the one being written.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_fault  = 1'b0;
        w_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MEM_store_req) begin
                    if (w_aligned) begin
                        w_accept = 1'b1;
                        w_stall  = 1'b1;
                        w_next   = S_REQ;
                    end else begin
                        w_fault  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_stall = ~DM_ready;
                if (DM_ready) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_bwe   <= 4'd0;
            r_fault <= 1'b0;
            r_faddr <= 32'd0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= {MEM_addr[31:2], 2'b00};
                r_wdata <= w_wdata;
                r_bwe   <= w_bwe;
            end
            // A faulting input held across cycles yields a pulse, not a level.
            r_fault <= w_fault & ~r_fault;
            if (w_fault)
                r_faddr <= MEM_addr;
            if (w_done)
                r_count <= r_count + 16'd1;
        end
    end

    assign DM_req          = (r_state == S_REQ);
    assign DM_addr         = r_addr;
    assign DM_wdata        = r_wdata;
    assign DM_bwe          = r_bwe;
    assign MEM_stall       = w_stall;
    assign MEM_store_fault = r_fault;
    assign fault_addr      = r_faddr;
    assign store_count     = r_count;

endmodule

// File: tb/tb_store_port_ctrl.sv
// Testbench for store_port_ctrl: directed scenarios, a random phase and a
// counter-wrap run, all checked cycle by cycle against a reference model.
`timescale 1ns/1ps
module tb_store_port_ctrl;

    logic        clk;
    logic        reset;
    logic        MEM_store_req;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_addr;
    logic [31:0] MEM_rs2_data;
    logic        DM_ready;
    logic        DM_req;
    logic [31:0] DM_addr;
    logic [31:0] DM_wdata;
    logic [3:0]  DM_bwe;
    logic        MEM_stall;
    logic        MEM_store_fault;
    logic [31:0] fault_addr;
    logic [15:0] store_count;

    store_port_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .MEM_store_req   (MEM_store_req),
        .MEM_funct3      (MEM_funct3),
        .MEM_addr        (MEM_addr),
        .MEM_rs2_data    (MEM_rs2_data),
        .DM_ready        (DM_ready),
        .DM_req          (DM_req),
        .DM_addr         (DM_addr),
        .DM_wdata        (DM_wdata),
        .DM_bwe          (DM_bwe),
        .MEM_stall       (MEM_stall),
        .MEM_store_fault (MEM_store_fault),
        .fault_addr      (fault_addr),
        .store_count     (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit do_chk = 1'b1;

    // Reference model: one outstanding store, described by what memory
    // should see, plus the fault and completion bookkeeping.
    bit          m_busy;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_bwe;
    bit          m_fault;
    logic [31:0] m_faddr;
    logic [15:0] m_cnt;

    function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 1'b1;
            3'd1:    return (a % 2) == 0;
            3'd2:    return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return 32'(d[7:0]) * 32'h0101_0101;
            3'd1:    return 32'(d[15:0]) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] m_lanes(input logic [2:0] f3, input logic [31:0] a);
        int b;
        b = int'(a % 4);
        case (f3)
            3'd0:    return 4'(1 << b);
            3'd1:    return 4'(3 << (b & 2));
            default: return 4'hF;
        endcase
    endfunction

    task automatic m_reset();
        m_busy = 0; m_addr = '0; m_wdata = '0; m_bwe = '0;
        m_fault = 0; m_faddr = '0; m_cnt = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        bit exp_stall;
        exp_stall = m_busy ? !DM_ready : (MEM_store_req && m_aligned(MEM_funct3, MEM_addr));
        chk("dm_req",   32'(DM_req),          32'(m_busy));
        chk("stall",    32'(MEM_stall),       32'(exp_stall));
        chk("fault",    32'(MEM_store_fault), 32'(m_fault));
        chk("fault_addr", fault_addr,         m_faddr);
        chk("count",    32'(store_count),     32'(m_cnt));
        if (m_busy) begin
            chk("dm_addr",  DM_addr,          m_addr);
            chk("dm_wdata", DM_wdata,         m_wdata);
            chk("dm_bwe",   32'(DM_bwe),      32'(m_bwe));
        end
    endtask

    // Advance the model over one rising edge using the current inputs.
    task automatic model_edge();
        bit rejected;
        rejected = !m_busy && MEM_store_req && !m_aligned(MEM_funct3, MEM_addr);
        m_fault = rejected && !m_fault;
        if (rejected) m_faddr = MEM_addr;
        if (m_busy) begin
            if (DM_ready) begin
                m_busy = 0;
                m_cnt  = m_cnt + 16'd1;
            end
        end else if (MEM_store_req && m_aligned(MEM_funct3, MEM_addr)) begin
            m_busy  = 1;
            m_addr  = MEM_addr & 32'hFFFF_FFFC;
            m_wdata = m_data(MEM_funct3, MEM_rs2_data);
            m_bwe   = m_lanes(MEM_funct3, MEM_addr);
        end
    endtask

    // One clock cycle: called 1 ns after a rising edge.
    task automatic step(input bit req, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit rdy);
        MEM_store_req = req;
        MEM_funct3    = f3;
        MEM_addr      = a;
        MEM_rs2_data  = d;
        DM_ready      = rdy;
        #1;
        if (do_chk) check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        MEM_store_req = 1'b0; MEM_funct3 = 3'd0; MEM_addr = '0;
        MEM_rs2_data = '0; DM_ready = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        chk("rst_dm_req",   32'(DM_req),          32'd0);
        chk("rst_dm_addr",  DM_addr,              32'd0);
        chk("rst_dm_wdata", DM_wdata,             32'd0);
        chk("rst_dm_bwe",   32'(DM_bwe),          32'd0);
        chk("rst_fault",    32'(MEM_store_fault), 32'd0);
        chk("rst_count",    32'(store_count),     32'd0);
        reset = 1'b1;

        // Reset in the middle of a request abandons it without counting.
        step(1, 3'd2, 32'h0000_0100, 32'h1111_2222, 0);
        step(1, 3'd2, 32'h0000_0100, 32'h1111_2222, 0);
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        chk("abort_dm_req", 32'(DM_req),      32'(m_busy));
        chk("abort_count",  32'(store_count), 32'(m_cnt));
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 3'd0, 32'h0, 32'h0, 1);

        // SW with memory ready immediately.
        step(1, 3'd2, 32'h1000_0008, 32'hDEAD_BEEF, 1);
        step(1, 3'd2, 32'h1000_0008, 32'hDEAD_BEEF, 1);
        step(0, 3'd0, 32'h0, 32'h0, 1);
        chk("sw_count", 32'(store_count), 32'd1);

        // SB to the top byte lane.
        step(1, 3'd0, 32'h0000_0013, 32'h0000_00A5, 1);
        step(1, 3'd0, 32'h0000_0013, 32'h0000_00A5, 1);
        step(0, 3'd0, 32'h0, 32'h0, 0);

        // SH upper half with memory busy for three cycles.
        step(1, 3'd1, 32'h0000_0022, 32'h1234_BEEF, 0);
        for (int i = 0; i < 3; i++)
            step(1, 3'd1, 32'h0000_0022, 32'h1234_BEEF, 0);
        step(1, 3'd1, 32'h0000_0022, 32'h1234_BEEF, 1);
        step(0, 3'd0, 32'h0, 32'h0, 0);
        chk("sh_count", 32'(store_count), 32'd3);

        // Misaligned SW, then illegal funct3; last one held two cycles.
        step(1, 3'd2, 32'h0000_0006, 32'h5555_5555, 0);
        step(0, 3'd0, 32'h0, 32'h0, 0);
        step(0, 3'd0, 32'h0, 32'h0, 0);
        step(1, 3'd3, 32'h0000_0008, 32'h5555_5555, 1);
        step(1, 3'd3, 32'h0000_0008, 32'h5555_5555, 1);
        step(0, 3'd0, 32'h0, 32'h0, 0);
        step(0, 3'd0, 32'h0, 32'h0, 0);

        // Random traffic, including ready while idle and illegal widths.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom,
                 $urandom, 1'($urandom_range(0, 1)));
        step(0, 3'd0, 32'h0, 32'h0, 1);
        step(0, 3'd0, 32'h0, 32'h0, 1);

        // Bring the count to 16'hFFFF, then one more completion wraps it.
        do_chk = 1'b0;
        while (m_cnt != 16'hFFFF) begin
            step(1, 3'd2, 32'h0000_0040, 32'hA5A5_0000, 1);
            step(0, 3'd0, 32'h0, 32'h0, 1);
        end
        do_chk = 1'b1;
        step(0, 3'd0, 32'h0, 32'h0, 1);
        chk("pre_wrap", 32'(store_count), 32'h0000_FFFF);
        step(1, 3'd0, 32'h0000_0041, 32'h0000_0077, 1);
        step(0, 3'd0, 32'h0, 32'h0, 1);
        step(0, 3'd0, 32'h0, 32'h0, 1);
        chk("wrap", 32'(store_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_port_ctrl.md
STORE_PORT_CTRL -- requirements
Module: store_port_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clk.
REQ-003 MEM_store_req  input  1  MEM-stage instruction is a store; held stable by pipeline while MEM_stall=1.
REQ-004 MEM_funct3  input  3  store width: 3'd0 SB, 3'd1 SH, 3'd2 SW; other codes illegal.
REQ-005 MEM_addr  input  32  byte address from ALU.
REQ-006 MEM_rs2_data  input  32  store data, LSB-aligned.
REQ-007 DM_ready  input  1  data memory accepts the current request this cycle.
REQ-008 DM_req  output  1  write request valid to data memory.
REQ-009 DM_addr  output  32  word-aligned address, bits [1:0] always 2'b00.
REQ-010 DM_wdata  output  32  lane-replicated write data.
REQ-011 DM_bwe  output  4  active-high byte write enables; bit n covers DM_wdata[8n+7:8n].
REQ-012 MEM_stall  output  1  freeze IF/ID/EX/MEM registers and MEM inputs.
REQ-013 MEM_store_fault  output  1  one-cycle pulse: misaligned or illegal store rejected.
REQ-014 fault_addr  output  32  MEM_addr of the most recent rejected store.
REQ-015 store_count  output  16  number of completed DM handshakes, modulo 2^16.

Function
REQ-016 FSM states SHALL be IDLE and REQ only.
REQ-017 aligned = (funct3=0) | (funct3=1 & addr[0]=0) | (funct3=2 & addr[1:0]=0); any other funct3 SHALL count as not aligned.
REQ-018 In IDLE with MEM_store_req=1 and aligned: latch DM_addr={MEM_addr[31:2],2'b00}, DM_wdata, DM_bwe; go to REQ; DM_req=1 from the next cycle.
REQ-019 SB: DM_wdata={4{rs2[7:0]}}, DM_bwe=4'b0001<<addr[1:0].
REQ-020 SH: DM_wdata={2{rs2[15:0]}}, DM_bwe=addr[1]?4'b1100:4'b0011.
REQ-021 SW: DM_wdata=rs2, DM_bwe=4'b1111.
REQ-022 In REQ, DM_req, DM_addr, DM_wdata, DM_bwe SHALL be held constant until the DM_req&DM_ready cycle.
REQ-023 On the DM_req&DM_ready edge: go to IDLE, DM_req=0 next cycle, store_count increments by 1 (16'hFFFF wraps to 0).
REQ-024 MEM_stall is combinational: 1 when (IDLE & MEM_store_req & aligned) or (REQ & !DM_ready); otherwise 0.
REQ-025 In REQ, MEM_store_req is ignored; the handshake-cycle inputs are the held store and SHALL NOT start a second request.
REQ-026 In IDLE with MEM_store_req=1 and not aligned: no DM request; MEM_stall=0; MEM_store_fault=1 the next cycle only; fault_addr<=MEM_addr.
REQ-027 MEM_store_fault SHALL deassert after one cycle even if the faulting inputs persist, and re-pulse for each new faulting cycle in IDLE.
REQ-028 Minimum store occupancy: accept cycle plus one REQ cycle (DM_ready=1 on first DM_req cycle) = 2 cycles, 1 stall cycle.
REQ-029 DM_ready while DM_req=0 SHALL be ignored.

Reset
REQ-030 reset=0 SHALL force state=IDLE, DM_req=0, DM_addr=0, DM_wdata=0, DM_bwe=0, MEM_store_fault=0, fault_addr=0, store_count=0, asynchronously.
REQ-031 Reset asserted in REQ SHALL abandon the request without incrementing store_count; DM_req drops without waiting for clk.
REQ-032 First accept is possible on the first rising edge after reset returns to 1.

Verification
REQ-033 SW addr=0x1000_0008 rs2=0xDEADBEEF, DM_ready=1 -> DM_req 1 cycle, DM_addr=0x1000_0008, bwe=1111, wdata=0xDEADBEEF, stall 1 cycle, store_count=1.
REQ-034 SB addr=0x0000_0013 rs2=0x0000_00A5 -> DM_addr=0x0000_0010, bwe=1000, wdata=0xA5A5A5A5.
REQ-035 SH addr=0x0000_0022 rs2=0x1234_BEEF, DM_ready low 3 cycles -> DM_req/addr/data/bwe=1100 stable 4 cycles, stall 4 cycles, single count increment.
REQ-036 SW addr=0x0000_0006 -> no DM_req, stall 0, MEM_store_fault 1-cycle pulse, fault_addr=0x0000_0006; funct3=3 likewise faults.
REQ-037 reset=0 mid-REQ (DM_ready=0) -> DM_req=0 immediately, store_count unchanged at 0; store_count preset via 65535 stores wraps to 0 on the next completion.
